// File: rtl/core_muldiv_unit_if.sv
// EX <-> multiply/divide unit bundle.
//   master (EX side): drives start/op/word/a/b/flush/hi_we/lo_we/wdata,
//                     observes hi/lo/busy/done.
//   slave  (unit side): the mirror image.
interface core_muldiv_unit_if #(
    parameter int unsigned WIDTH = 64
) ();
    logic             start;
    logic [1:0]       op;
    logic             word;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, word, a, b, flush, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, word, a, b, flush, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/core_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Retires UNROLL bits per ITER cycle; a W-bit op takes W/UNROLL + 2 cycles.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   mdu      slave side of core_muldiv_unit_if: start/op/word/a/b/flush,
//            hi_we/lo_we/wdata (MTHI/MTLO), hi/lo/busy/done (all registered)
module core_muldiv_unit #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned UNROLL = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    core_muldiv_unit_if.slave mdu
);
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned N_WORD = 32 / UNROLL;
    localparam int unsigned N_FULL = WIDTH / UNROLL;
    localparam int unsigned ALIGN  = WIDTH - 32;
    localparam logic [WIDTH-1:0] MASK32 = WIDTH'(32'hFFFF_FFFF);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               word_q, word_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   dv_q, dv_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               word_in;
    logic               is_signed, sign_a, sign_b;
    logic [WIDTH-1:0]   wmask, a_w, b_w, a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    function automatic logic [WIDTH-1:0] sext32(input logic [31:0] x);
        return WIDTH'($signed(x));
    endfunction

    // UNROLL steps of MSB-first shift-add (mul) or restoring shift-subtract (div).
    // Mul: acc = product, sh = multiplier, dv = multiplicand.
    // Div: acc[WIDTH-1:0] = partial remainder, sh = dividend in / quotient out, dv = divisor.
    function automatic logic [3*WIDTH-1:0] step_n(input logic div,
                                                   input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0] sh,
                                                   input logic [WIDTH-1:0] dv);
        logic [2*WIDTH-1:0] a;
        logic [WIDTH-1:0]   s;
        logic [WIDTH:0]     rr;
        a = acc;
        s = sh;
        for (int i = 0; i < int'(UNROLL); i++) begin
            if (div) begin
                rr = {a[WIDTH-1:0], s[WIDTH-1]};
                if (rr >= {1'b0, dv}) begin
                    rr = rr - {1'b0, dv};
                    s  = {s[WIDTH-2:0], 1'b1};
                end else begin
                    s  = {s[WIDTH-2:0], 1'b0};
                end
                a = (2*WIDTH)'(rr);
            end else begin
                a = (a << 1) + (s[WIDTH-1] ? (2*WIDTH)'(dv) : '0);
                s = s << 1;
            end
        end
        return {a, s};
    endfunction

    // 32-bit datapath has only word ops.
    assign word_in = (WIDTH == 32) ? 1'b1 : mdu.word;

    // Operand magnitudes and signs, consumed in PREP.
    assign is_signed = ~op_q[0];
    assign wmask     = word_q ? MASK32 : '1;
    assign sign_a    = word_q ? a_q[31] : a_q[WIDTH-1];
    assign sign_b    = word_q ? b_q[31] : b_q[WIDTH-1];
    assign a_w       = a_q & wmask;
    assign b_w       = b_q & wmask;
    assign a_mag     = ((is_signed && sign_a) ? -a_w : a_w) & wmask;
    assign b_mag     = ((is_signed && sign_b) ? -b_w : b_w) & wmask;

    // Sign fix-up and HI/LO mapping, consumed in FIX.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        prod   = neg_quo_q ? -acc_q : acc_q;
        quo    = neg_quo_q ? -sh_q : sh_q;
        rem    = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        if (!op_q[1]) begin
            res_hi = word_q ? sext32(prod[63:32]) : prod[2*WIDTH-1:WIDTH];
            res_lo = word_q ? sext32(prod[31:0])  : prod[WIDTH-1:0];
        end else if (dz_q) begin
            res_hi = word_q ? sext32(a_q[31:0]) : a_q;
            res_lo = '1;
        end else begin
            res_hi = word_q ? sext32(rem[31:0]) : rem;
            res_lo = word_q ? sext32(quo[31:0]) : quo;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        word_d    = word_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        dv_d      = dv_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mdu.hi_we) hi_d = mdu.wdata;
                if (mdu.lo_we) lo_d = mdu.wdata;
                if (mdu.start && !mdu.flush) begin
                    op_d    = mdu.op;
                    word_d  = word_in;
                    a_d     = mdu.a;
                    b_d     = mdu.b;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                acc_d     = '0;
                cnt_d     = word_q ? CNT_W'(N_WORD) : CNT_W'(N_FULL);
                neg_quo_d = is_signed && (sign_a ^ sign_b);
                neg_rem_d = is_signed && sign_a;
                dz_d      = (b_w == '0);
                // Word operands are left-aligned so the MSB-first loop sees them first.
                if (op_q[1]) begin
                    sh_d = word_q ? (a_mag << ALIGN) : a_mag;
                    dv_d = b_mag;
                end else begin
                    sh_d = word_q ? (b_mag << ALIGN) : b_mag;
                    dv_d = a_mag;
                end
                state_d = S_ITER;
            end
            S_ITER: begin
                {acc_d, sh_d} = step_n(op_q[1], acc_q, sh_q, dv_q);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Squashed op: abandon without touching HI/LO.
        if (mdu.flush && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            word_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            acc_q     <= '0;
            sh_q      <= '0;
            dv_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            word_q    <= word_d;
            a_q       <= a_d;
            b_q       <= b_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            dv_q      <= dv_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
    assign mdu.busy = busy_q;
    assign mdu.done = done_q;
endmodule

// File: tb/tb_core_muldiv_unit.sv
// Directed bench for core_muldiv_unit: UNROLL=1 and UNROLL=4 instances, WIDTH=64.
module tb_core_muldiv_unit;
    logic clock;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    core_muldiv_unit_if #(.WIDTH(64)) bus1 ();
    core_muldiv_unit_if #(.WIDTH(64)) bus4 ();

    core_muldiv_unit #(.WIDTH(64), .UNROLL(1)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .mdu     (bus1)
    );

    core_muldiv_unit #(.WIDTH(64), .UNROLL(4)) u_dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .mdu     (bus4)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; launches one op on bus1 and checks latency and result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b, input int exp_lat,
                          input logic [63:0] exp_hi, input logic [63:0] exp_lo);
        int k;
        bus1.op    = op;
        bus1.word  = word;
        bus1.a     = a;
        bus1.b     = b;
        bus1.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus1.start = 1'b0;
        check({tag, "_busy"}, 64'(bus1.busy), 64'd1);
        k = 0;
        while (!bus1.done && k < 200) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(exp_lat));
        check({tag, "_hi"}, bus1.hi, exp_hi);
        check({tag, "_lo"}, bus1.lo, exp_lo);
        check({tag, "_idle"}, 64'(bus1.busy), 64'd0);
        @(negedge clock);
        check({tag, "_done1"}, 64'(bus1.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int seen_done;
        int seen_busy;
        tests_run    = 0;
        tests_failed = 0;
        clock   = 1'b0;
        reset_n = 1'b0;
        bus1.start = 1'b0; bus1.op = 2'b00; bus1.word = 1'b0; bus1.a = '0; bus1.b = '0;
        bus1.flush = 1'b0; bus1.hi_we = 1'b0; bus1.lo_we = 1'b0; bus1.wdata = '0;
        bus4.start = 1'b0; bus4.op = 2'b00; bus4.word = 1'b0; bus4.a = '0; bus4.b = '0;
        bus4.flush = 1'b0; bus4.hi_we = 1'b0; bus4.lo_we = 1'b0; bus4.wdata = '0;

        repeat (3) @(negedge clock);
        check("rst_hi", bus1.hi, 64'd0);
        check("rst_lo", bus1.lo, 64'd0);
        check("rst_busy", 64'(bus1.busy), 64'd0);
        check("rst_done", 64'(bus1.done), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op("mult_w",  2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 34,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("dmultu",  2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 66,
               64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001);
        run_op("ddiv",    2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_z",  2'b11, 1'b1, 64'd5, 64'd0, 34,
               64'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("ddiv_ov", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 66,
               64'd0, 64'h8000_0000_0000_0000);

        // MTHI / MTLO share wdata, so one per cycle.
        bus1.hi_we = 1'b1; bus1.wdata = 64'h11;
        @(negedge clock);
        bus1.hi_we = 1'b0; bus1.lo_we = 1'b1; bus1.wdata = 64'h22;
        @(negedge clock);
        bus1.lo_we = 1'b0;
        check("mthi", bus1.hi, 64'h11);
        check("mtlo", bus1.lo, 64'h22);

        // DMULT flushed mid-iteration, with a competing start.
        bus1.op = 2'b01; bus1.word = 1'b0; bus1.a = 64'd3; bus1.b = 64'd5; bus1.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus1.start = 1'b0;
        repeat (11) @(negedge clock);
        bus1.flush = 1'b1; bus1.start = 1'b1; bus1.a = 64'd7; bus1.b = 64'd9;
        @(negedge clock);
        bus1.flush = 1'b0; bus1.start = 1'b0;
        check("flush_busy", 64'(bus1.busy), 64'd0);
        check("flush_done", 64'(bus1.done), 64'd0);
        check("flush_hi", bus1.hi, 64'h11);
        check("flush_lo", bus1.lo, 64'h22);
        seen_done = 0;
        seen_busy = 0;
        repeat (80) begin
            @(negedge clock);
            if (bus1.done) seen_done++;
            if (bus1.busy) seen_busy++;
        end
        check("flush_nodone", 64'(seen_done), 64'd0);
        check("flush_nostart", 64'(seen_busy), 64'd0);

        // MTHI while busy is dropped.
        bus1.op = 2'b01; bus1.a = 64'd1; bus1.b = 64'd1; bus1.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus1.start = 1'b0; bus1.hi_we = 1'b1; bus1.wdata = 64'h99;
        @(negedge clock);
        bus1.hi_we = 1'b0;
        @(negedge clock);
        bus1.flush = 1'b1;
        @(negedge clock);
        bus1.flush = 1'b0;
        check("mthi_busy_hi", bus1.hi, 64'h11);
        check("mthi_busy_lo", bus1.lo, 64'h22);

        // Asynchronous reset mid-op.
        bus1.op = 2'b01; bus1.a = 64'd3; bus1.b = 64'd5; bus1.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus1.start = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_hi", bus1.hi, 64'd0);
        check("arst_lo", bus1.lo, 64'd0);
        check("arst_busy", 64'(bus1.busy), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // UNROLL=4 DMULT 3*5.
        bus4.op = 2'b00; bus4.word = 1'b0; bus4.a = 64'd3; bus4.b = 64'd5; bus4.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus4.start = 1'b0;
        check("u4_busy", 64'(bus4.busy), 64'd1);
        k = 0;
        while (!bus4.done && k < 200) begin
            @(negedge clock);
            k++;
        end
        check("u4_lat", 64'(k), 64'd18);
        check("u4_lo", bus4.lo, 64'd15);
        check("u4_hi", bus4.hi, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/core_muldiv_unit.md
# core_muldiv_unit

Iterative integer multiply/divide unit that sits beside the EX stage and owns the architectural HI/LO registers. It is a parametrised successor to the single-cycle ALU/barrel datapath. It executes MULT/MULTU/DIV/DIVU and their 64-bit D-forms over multiple cycles, processing a configurable number of bits per cycle. EX uses `busy` to stall MFHI/MFLO, and `flush` to cancel a squashed operation.

## Interface
- `WIDTH`, default 64: datapath width; legal values are 32 and 64.
- `UNROLL`, default 1: bits retired per iteration cycle; legal values are 1, 2 and 4; must divide 32.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `start`  in  1  launch request; accepted only when `busy`=0.
- `op`  in  2  operation select: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- `word`  in  1  1 = 32-bit op on `a[31:0]`/`b[31:0]`; ignored (treated as 1) when `WIDTH`=32.
- `a`  in  WIDTH  multiplicand/dividend (forwarded rs).
- `b`  in  WIDTH  multiplier/divisor (forwarded rt).
- `flush`  in  1  synchronous cancel of any in-flight op.
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write enables.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi`, `lo`  out  WIDTH  architectural HI/LO.
- `busy`  out  1  op in flight.
- `done`  out  1  one-cycle pulse on the edge HI/LO take a result.

## Operation
- States: IDLE, PREP, ITER, FIX.
- IDLE: `start`&&!`flush` latches `op`, `word`, `a`, `b`, then goes to PREP.
- PREP: computes operand magnitudes for signed ops (sign bits taken from bit 31 if word, else bit WIDTH-1) and records the result signs. Loads the iteration counter with N = W/UNROLL, where W = 32 if word, else WIDTH. Goes to ITER.
- ITER: retires UNROLL bits per cycle and decrements the counter. At 0 it goes to FIX.
  - Multiply: shift-add into a 2W-bit accumulator.
  - Divide: restoring shift-subtract yields quotient and remainder.
- FIX: applies the signs, writes HI/LO, pulses `done`, returns to IDLE.
- Sign rules:
  - Signed multiply: negate the product if the operand signs differ.
  - Signed divide: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
- Result mapping:
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
  - word ops with WIDTH=64: each 32-bit half is sign-extended to 64 bits.
- Divide by zero (defined here; MIPS leaves it undefined): LO = all ones of W bits (sign-extended if word), HI = the dividend as given.
- Signed MIN / -1: LO = MIN, HI = 0. No trap; overflow is not reported.
- MTHI/MTLO: when `busy`=0, `hi_we`/`lo_we` write `wdata` on the edge. When `busy`=1 the write is dropped.
- `start` and `hi_we` in the same idle cycle: both take effect; the op's result later overwrites HI/LO.
- `flush` while not IDLE: next state is IDLE, `busy` falls, HI/LO are unchanged, no `done`.
- `flush` together with `start`: flush wins and `start` is dropped.
- `start` while `busy`: ignored, with no queueing; upstream stalls.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0. Assertion is asynchronous and aborts any op; release is synchronous to `clock`.
- Latency: accept edge t0; `busy`=1 from after t0 through edge t0+N+2. FIX writes HI/LO and pulses `done` on edge t0+N+2; `busy` falls on that same edge.
- Total cycles = N+2. Examples: DMULT with UNROLL=1 takes 66 cycles; MULT with UNROLL=1 takes 34; DMULT with UNROLL=4 takes 18.
- `done` is high for exactly one cycle after the writing edge. It is never asserted for a flushed op.
- A new `start` is accepted in the cycle `busy` is low, i.e. back-to-back with a gap of 0 idle cycles after `done`.
- `hi`/`lo` are outputs driven directly from registers; there is no combinational path from inputs.

## Test plan
- WIDTH=64, UNROLL=1; signed mul, word=1, a=0xFFFF_FFFF_FFFF_FFFD (-3), b=7 -> `done` 34 cycles after accept; LO=0xFFFF_FFFF_FFFF_FFEB, HI=0xFFFF_FFFF_FFFF_FFFF.
- Unsigned mul, word=0, a=b=0xFFFF_FFFF_FFFF_FFFF -> `done` after 66 cycles; HI=0xFFFF_FFFF_FFFF_FFFE, LO=0x1.
- Signed div, word=0, a=-7, b=2 -> LO=0xFFFF_FFFF_FFFF_FFFD (-3), HI=0xFFFF_FFFF_FFFF_FFFF (-1).
- Unsigned div, word=1, a=5, b=0 -> LO=0xFFFF_FFFF_FFFF_FFFF, HI=5.
- Signed div, word=0, a=0x8000_0000_0000_0000, b=-1 -> LO=0x8000_0000_0000_0000, HI=0.
- Flush, MTHI and reset sequence:
  1. Set HI=0x11, LO=0x22 via MTHI/MTLO.
  2. Start DMULT; assert `flush` together with `start` at iteration 10 -> `busy` is 0 on the next edge, HI/LO stay 0x11/0x22, no `done`, the second `start` is ignored.
  3. MTHI while busy is dropped.
  4. Drop `reset_n` mid-op -> HI=LO=0 and `busy`=0 immediately.
  5. UNROLL=4 DMULT of 3*5 -> LO=15 after 18 cycles.
